// File: rtl/npu_pkg.sv
// npu_pkg: shared constants for the NPU MAC sequencer.
// State encoding, default data format and an address-width helper.
package npu_pkg;

    localparam int NPU_DATA_WIDTH = 8;
    localparam int NPU_FRAC_BITS  = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Ceil log2 with a floor of 1 so single-entry spaces still get a bit.
    function automatic int npu_clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/npu_seq_idx_cnt.sv
// npu_seq_idx_cnt: nested (neuron, input) issue counter for the MAC sequencer.
// Provides first/last flags and the linear weight address n*NUM_IN+i.
module npu_seq_idx_cnt
    import npu_pkg::*;
#(
    parameter int NUM_IN   = 16,
    parameter int NUM_OUT  = 8,
    parameter int W_ADDR_W = npu_clog2(NUM_IN * NUM_OUT),
    parameter int A_ADDR_W = npu_clog2(NUM_IN),
    parameter int O_ADDR_W = npu_clog2(NUM_OUT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    input  logic                adv_i,
    output logic [A_ADDR_W-1:0] i_o,
    output logic [W_ADDR_W-1:0] w_addr_o,
    output logic                i_first_o,
    output logic                i_last_o,
    output logic                all_last_o
);

    logic [A_ADDR_W-1:0] i_q, i_d;
    logic [O_ADDR_W-1:0] n_q, n_d;
    logic [W_ADDR_W-1:0] w_q, w_d;
    logic                n_last;

    assign i_first_o  = (i_q == '0);
    assign i_last_o   = (i_q == A_ADDR_W'(NUM_IN - 1));
    assign n_last     = (n_q == O_ADDR_W'(NUM_OUT - 1));
    assign all_last_o = i_last_o & n_last;
    assign i_o        = i_q;
    assign w_addr_o   = w_q;

    // Weight address advances linearly, so no multiplier is needed.
    always_comb begin
        i_d = i_q;
        n_d = n_q;
        w_d = w_q;
        if (clr_i) begin
            i_d = '0;
            n_d = '0;
            w_d = '0;
        end else if (adv_i) begin
            w_d = all_last_o ? '0 : w_q + 1'b1;
            if (i_last_o) begin
                i_d = '0;
                n_d = n_last ? '0 : n_q + 1'b1;
            end else begin
                i_d = i_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            n_q <= '0;
            w_q <= '0;
        end else begin
            i_q <= i_d;
            n_q <= n_d;
            w_q <= w_d;
        end
    end

endmodule

// File: rtl/npu_mac_seq.sv
// npu_mac_seq: fully-connected layer sequencer driving one npu_mac instance.
// Define NPU_SEQ_RELU_EN to clamp negative results to zero on writeback.
module npu_mac_seq
    import npu_pkg::*;
#(
    parameter int DATA_WIDTH = NPU_DATA_WIDTH,
    parameter int NUM_IN     = 16,
    parameter int NUM_OUT    = 8,
    parameter int W_ADDR_W   = npu_clog2(NUM_IN * NUM_OUT),
    parameter int A_ADDR_W   = npu_clog2(NUM_IN),
    parameter int O_ADDR_W   = npu_clog2(NUM_OUT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf_sticky,
    output logic                  w_rd_en,
    output logic [W_ADDR_W-1:0]   w_addr,
    output logic                  a_rd_en,
    output logic [A_ADDR_W-1:0]   a_addr,
    output logic                  mac_en,
    output logic                  mac_start_p,
    output logic                  mac_last_p,
    input  logic                  mac_valid,
    input  logic [DATA_WIDTH-1:0] mac_out,
    input  logic                  mac_overflow,
    output logic                  o_wr_en,
    output logic [O_ADDR_W-1:0]   o_addr,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [1:0]            state_q, state_d;
    logic                  issue, run_busy, accept, cap, last_wr;
    logic                  i_first, i_last, all_last;
    logic                  en_q, start_q, last_q, ovf_q, wr_q;
    logic [O_ADDR_W-1:0]   wr_cnt_q, addr_q;
    logic [DATA_WIDTH-1:0] data_q, wb_data;

    npu_seq_idx_cnt #(
        .NUM_IN   (NUM_IN),
        .NUM_OUT  (NUM_OUT),
        .W_ADDR_W (W_ADDR_W),
        .A_ADDR_W (A_ADDR_W),
        .O_ADDR_W (O_ADDR_W)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst),
        .clr_i      (accept),
        .adv_i      (issue),
        .i_o        (a_addr),
        .w_addr_o   (w_addr),
        .i_first_o  (i_first),
        .i_last_o   (i_last),
        .all_last_o (all_last)
    );

    assign issue    = (state_q == ST_RUN);
    assign run_busy = issue | (state_q == ST_DRAIN);
    assign accept   = start & (state_q == ST_IDLE);
    assign cap      = mac_valid & run_busy;
    assign last_wr  = wr_q & (addr_q == O_ADDR_W'(NUM_OUT - 1));

`ifdef NPU_SEQ_RELU_EN
    assign wb_data = mac_out[DATA_WIDTH-1] ? '0 : mac_out;
`else
    assign wb_data = mac_out;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (all_last) state_d = ST_DRAIN;
            ST_DRAIN: if (last_wr) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Issue flags are delayed one cycle to line up with the RAM read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            en_q     <= 1'b0;
            start_q  <= 1'b0;
            last_q   <= 1'b0;
            wr_q     <= 1'b0;
            data_q   <= '0;
            addr_q   <= '0;
            wr_cnt_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= issue;
            start_q <= issue & i_first;
            last_q  <= issue & i_last;
            wr_q    <= cap;
            if (cap) begin
                data_q <= wb_data;
                addr_q <= wr_cnt_q;
            end
            if (accept)
                wr_cnt_q <= '0;
            else if (cap)
                wr_cnt_q <= wr_cnt_q + 1'b1;
            if (accept)
                ovf_q <= 1'b0;
            else if (run_busy & mac_overflow)
                ovf_q <= 1'b1;
        end
    end

    assign busy        = run_busy;
    assign done        = (state_q == ST_DONE);
    assign ovf_sticky  = ovf_q;
    assign w_rd_en     = issue;
    assign a_rd_en     = issue;
    assign mac_en      = en_q;
    assign mac_start_p = start_q;
    assign mac_last_p  = last_q;
    assign o_wr_en     = wr_q;
    assign o_addr      = addr_q;
    assign o_data      = data_q;

endmodule
